// File: rtl/interlock_ctrl_u.sv
// Pipeline interlock for NUM_PORTS memory ports with stall-length watchdog and sticky timeout error.
// Optional stall performance counter is built when INTERLOCK_PERF_EN is defined.
module interlock_ctrl_u #(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int PORT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] ack_n,
  input  logic                 err_clr,
  output logic                 interlock,
  output logic [TIMEOUT_W-1:0] stall_len,
  output logic                 timeout_err,
  output logic [PORT_W-1:0]    err_port,
  output logic [31:0]          stall_total
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam logic [TIMEOUT_W-1:0] LAST_LEN = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_r, state_nxt_s;
  logic [TIMEOUT_W-1:0]   len_r, len_nxt_s;
  logic                   err_r, err_nxt_s;
  logic [PORT_W-1:0]      port_r, port_nxt_s;
  logic [NUM_PORTS-1:0]   pending_s;
  logic                   any_pend_s;
  logic                   interlock_s;
  logic [PORT_W-1:0]      low_idx_s;

  assign pending_s  = req & ack_n;
  assign any_pend_s = |pending_s;

  // Lowest-index pending port; scanning downward lets the lowest index win.
  always_comb begin
    low_idx_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending_s[i]) begin
        low_idx_s = PORT_W'(i);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
  end

  // Next-state, watchdog bookkeeping and combinational interlock.
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    err_nxt_s   = err_r;
    port_nxt_s  = port_r;
    interlock_s = any_pend_s;
    case (state_r)
      IDLE: begin
        if (any_pend_s) begin
          if (TIMEOUT_CYCLES == 1) begin
            state_nxt_s = ERROR;
            err_nxt_s   = 1'b1;
            port_nxt_s  = low_idx_s;
          end else begin
            state_nxt_s = WAIT;
            len_nxt_s   = TIMEOUT_W'(1);
          end
        end else begin
          len_nxt_s = '0;
        end
      end
      WAIT: begin
        if (!any_pend_s) begin
          state_nxt_s = IDLE;
          len_nxt_s   = '0;
        end else if (len_r == LAST_LEN) begin
          state_nxt_s = ERROR;
          err_nxt_s   = 1'b1;
          port_nxt_s  = low_idx_s;
        end else begin
          len_nxt_s = len_r + TIMEOUT_W'(1);
        end
      end
      ERROR: begin
        // Pending requests in the clearing cycle are re-evaluated from IDLE next cycle.
        interlock_s = 1'b1;
        if (err_clr) begin
          state_nxt_s = IDLE;
          err_nxt_s   = 1'b0;
          len_nxt_s   = '0;
        end else begin
          state_nxt_s = ERROR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        len_nxt_s   = '0;
        err_nxt_s   = 1'b0;
        interlock_s = 1'b1;
      end
    endcase
  end

  // State and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      len_r   <= '0;
      err_r   <= 1'b0;
      port_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      err_r   <= err_nxt_s;
      port_r  <= port_nxt_s;
    end
  end

  assign interlock   = interlock_s;
  assign stall_len   = len_r;
  assign timeout_err = err_r;
  assign err_port    = port_r;

`ifdef INTERLOCK_PERF_EN
  logic [31:0] total_r;

  // Saturating count of stalled edges; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_r <= 32'd0;
    end else if (interlock_s && (total_r != 32'hFFFF_FFFF)) begin
      total_r <= total_r + 32'd1;
    end else begin
      total_r <= total_r;
    end
  end

  assign stall_total = total_r;
`else
  assign stall_total = 32'd0;
`endif

endmodule

// File: doc/interlock_ctrl_u.md
Name: interlock_ctrl_u

Overview:
- Parametrised successor to the pipeline interlock unit.
- Generalised from fixed imem/dmem to NUM_PORTS memory ports, each gated by its own request qualifier.
- Adds consecutive-stall counting, a watchdog timeout with sticky error and latched culprit port, and an optional stall performance counter.
- Sits between the memory interfaces and the pipeline-register enables. Its interlock output freezes every stage.

Parameters:
- NUM_PORTS, 2, number of memory ports monitored (≥1).
- TIMEOUT_W, 8, width of the stall-length counter.
- TIMEOUT_CYCLES, 255, consecutive stalled cycles before a timeout (1 ≤ value ≤ 2^TIMEOUT_W−1).
- Derived localparam PORT_W = max(1, clog2(NUM_PORTS)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  port i has an outstanding access this cycle.
- ack_n  in  NUM_PORTS  active-low acknowledge per port.
- err_clr  in  1  clears the timeout error. Honoured only in state ERROR.
- interlock  out  1  stall all pipeline stages.
- stall_len  out  TIMEOUT_W  current consecutive stalled-cycle count.
- timeout_err  out  1  sticky watchdog error.
- err_port  out  PORT_W  index of the lowest pending port at timeout.
- stall_total  out  32  cumulative stalled cycles (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous, active-high. rst has priority over every other input.
- Reset values: state=IDLE, stall_len=0, timeout_err=0, err_port=0, stall_total=0.
- pending[i] = req[i] & ack_n[i]. any_pend = OR over pending.
- interlock is combinational:
  - any_pend in IDLE/WAIT, so it has zero-cycle latency, same as the previous unit.
  - Forced 1 in ERROR.
- A port with req=0 never stalls, whatever its ack_n.
- States are IDLE, WAIT, ERROR.
- IDLE:
  - any_pend → WAIT, stall_len ← 1.
  - Otherwise stay, stall_len ← 0.
- WAIT:
  - !any_pend → IDLE, stall_len ← 0.
  - any_pend and stall_len == TIMEOUT_CYCLES−1 → ERROR; timeout_err ← 1; err_port ← lowest index i with pending[i]=1; stall_len holds.
  - Otherwise stall_len ← stall_len+1.
- TIMEOUT_CYCLES=1 means IDLE with any_pend goes directly to ERROR (err_port latched the same way).
- Net effect: ERROR is entered on the edge ending the TIMEOUT_CYCLES-th consecutive stalled cycle.
- ERROR:
  - interlock=1; timeout_err and err_port hold; req/ack_n are ignored.
  - err_clr=1 → IDLE; timeout_err ← 0; stall_len ← 0; err_port holds its last value.
  - pending in the err_clr cycle is not counted. It is re-evaluated from IDLE on the next cycle.
- err_clr outside ERROR has no effect.
- An ack arriving in the same cycle as the would-be timeout edge (any_pend=0) returns to IDLE; no error.
- stall_len never wraps. Its maximum is TIMEOUT_CYCLES−1 ≤ 2^TIMEOUT_W−2.
- Reset mid-stall or in ERROR returns to reset values on the next edge. interlock then follows any_pend immediately.

Optional Feature:
- Macro INTERLOCK_PERF_EN.
- Defined:
  - stall_total increments by 1 on each edge where interlock=1 (including ERROR cycles).
  - It saturates at 0xFFFFFFFF.
  - Cleared only by rst; err_clr does not clear it.
- Undefined: the counter register is not built and stall_total is tied to 0. The port list is unchanged.

Test Plan (NUM_PORTS=2, TIMEOUT_W=4, TIMEOUT_CYCLES=4):
- Truth check: with req=2'b11, ack_n = 00/01/10/11 each held 1 cycle → interlock 0/1/1/1. With req=2'b00, ack_n=2'b11 → interlock 0.
- Short stall: req=11, ack_n=10 for 3 cycles, then 00 → stall_len 1,2,3 then 0; timeout_err stays 0; state back in IDLE.
- Timeout: req=11, ack_n=11 held → after the 4th edge timeout_err=1, err_port=0, interlock=1.
  - Then ack_n=00 for 5 cycles → interlock stays 1.
  - Then err_clr pulse → next cycle timeout_err=0, stall_len=0, interlock=0.
- Culprit select: req=10, ack_n=11 held 4 cycles → err_port=1. Ack on the 4th cycle instead (ack_n=01 that cycle) → no error, IDLE.
- Reset mid-operation: assert rst in WAIT with stall_len=2, and separately in ERROR → next edge stall_len=0, timeout_err=0, stall_total=0.
- Perf (INTERLOCK_PERF_EN defined): 3-cycle stall + 4-cycle timeout + 2 ERROR cycles → stall_total=9. Macro undefined → stall_total stays 0 throughout.
